cache_ctrl: RTL

- Miss-handling controller for the 2-way set-associative write-back data cache (32-bit address, 23-bit tag [31:9], 5-bit index [8:4], 16-byte lines).
- Sits between the CPU load/store port, the cache block (load/replace/store/invalid/u_b_h_w/din in; hit/dout/valid/dirty/tag out) and a word-wide memory handshake.
- Sequences tag compare, dirty write-back and line fill.
- Stalls the CPU until each access completes.

---
 rtl/cache_ctrl_pkg.sv | 30 +++
 rtl/cache_perf_cnt.sv | 29 ++
 rtl/cache_ctrl.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/cache_ctrl_pkg.sv
// Shared types and address-field helpers for the D-cache miss controller.
// Field widths here describe the default 23/5/4 tag/index/offset split.
package cache_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPARE = 2'd1,
        WB      = 2'd2,
        FILL    = 2'd3
    } state_t;

    localparam logic [2:0] U_B_H_W_WORD = 3'b010;

    localparam int TAG_BITS    = 23;
    localparam int INDEX_BITS  = 5;
    localparam int OFFSET_BITS = 4;

    function automatic logic [TAG_BITS-1:0] addr_tag(input logic [31:0] a);
        return a[31:32-TAG_BITS];
    endfunction

    function automatic logic [INDEX_BITS-1:0] addr_index(input logic [31:0] a);
        return a[OFFSET_BITS+INDEX_BITS-1:OFFSET_BITS];
    endfunction

    function automatic logic [OFFSET_BITS-1:0] addr_offset(input logic [31:0] a);
        return a[OFFSET_BITS-1:0];
    endfunction

endpackage

// File: rtl/cache_perf_cnt.sv
// Hit / miss / write-back event counters for cache_ctrl.
// Present only when CACHE_CTRL_PERF_EN is defined.
`ifdef CACHE_CTRL_PERF_EN
module cache_perf_cnt (
    input  logic        clk,
    input  logic        rst,
    input  logic        hit_evt,
    input  logic        miss_evt,
    input  logic        wb_evt,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt,
    output logic [31:0] wb_cnt
);

    // Counters wrap naturally at 2^32.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
            wb_cnt   <= '0;
        end else begin
            if (hit_evt)  hit_cnt  <= hit_cnt + 32'd1;
            if (miss_evt) miss_cnt <= miss_cnt + 32'd1;
            if (wb_evt)   wb_cnt   <= wb_cnt + 32'd1;
        end
    end

endmodule
`endif

// File: rtl/cache_ctrl.sv
// Miss-handling controller for the 2-way write-back D-cache: tag compare,
// dirty-line write-back and line fill. Optional counters via CACHE_CTRL_PERF_EN.
module cache_ctrl
    import cache_ctrl_pkg::*;
#(
    parameter int         LINE_WORDS = 4,
    parameter int         TAG_W      = 23,
    parameter int         INDEX_W    = 5,
    parameter logic [2:0] WORD_SEL   = U_B_H_W_WORD
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cpu_req,
    input  logic             cpu_we,
    input  logic [31:0]      cpu_addr,
    input  logic [2:0]       cpu_u_b_h_w,
    input  logic [31:0]      cpu_wdata,
    output logic [31:0]      cpu_rdata,
    output logic             cpu_ack,
    output logic [31:0]      cache_addr,
    output logic             cache_load,
    output logic             cache_store,
    output logic             cache_replace,
    output logic             cache_invalid,
    output logic [2:0]       cache_u_b_h_w,
    output logic [31:0]      cache_din,
    input  logic             cache_hit,
    input  logic             cache_valid,
    input  logic             cache_dirty,
    input  logic [TAG_W-1:0] cache_tag,
    input  logic [31:0]      cache_dout,
    output logic             mem_req,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    input  logic [31:0]      mem_rdata,
    input  logic             mem_ack
`ifdef CACHE_CTRL_PERF_EN
    ,
    output logic [31:0]      hit_cnt,
    output logic [31:0]      miss_cnt,
    output logic [31:0]      wb_cnt
`endif
);

    localparam int CNT_W = $clog2(LINE_WORDS);
    localparam int OFF_W = 32 - TAG_W - INDEX_W;

    state_t             state, state_nx;
    logic [CNT_W-1:0]   cnt;
    logic [31:0]        req_addr, req_wdata;
    logic               req_we;
    logic [2:0]         req_size;
    logic [TAG_W-1:0]   victim_tag;
    logic               gap;
    logic               last_word, xfer_done;
    logic [31:0]        wb_addr, fill_addr;

    assign last_word = (cnt == CNT_W'(LINE_WORDS - 1));
    assign xfer_done = mem_req & mem_ack;
    assign wb_addr   = {victim_tag, req_addr[OFF_W+INDEX_W-1:OFF_W], cnt, 2'b00};
    assign fill_addr = {req_addr[31:OFF_W], cnt, 2'b00};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (cpu_req) state_nx = COMPARE;
            COMPARE: begin
                if (cache_hit)                       state_nx = IDLE;
                else if (cache_valid && cache_dirty) state_nx = WB;
                else                                 state_nx = FILL;
            end
            WB:      if (xfer_done && last_word) state_nx = FILL;
            FILL:    if (xfer_done && last_word) state_nx = COMPARE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        cpu_rdata     = '0;
        cpu_ack       = 1'b0;
        cache_addr    = '0;
        cache_load    = 1'b0;
        cache_store   = 1'b0;
        cache_replace = 1'b0;
        cache_invalid = 1'b0;
        cache_u_b_h_w = '0;
        cache_din     = '0;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        mem_addr      = '0;
        mem_wdata     = '0;
        case (state)
            COMPARE: begin
                cache_addr    = req_addr;
                cache_load    = ~req_we;
                cache_store   = req_we;
                cache_u_b_h_w = req_size;
                cache_din     = req_wdata;
                if (cache_hit) begin
                    cpu_ack   = 1'b1;
                    cpu_rdata = cache_dout;
                end
            end
            WB: begin
                cache_addr    = wb_addr;
                cache_load    = 1'b1;
                cache_u_b_h_w = WORD_SEL;
                mem_req       = rst;
                mem_we        = 1'b1;
                mem_addr      = wb_addr;
                mem_wdata     = cache_dout;
            end
            FILL: begin
                // One idle cycle after write-back so memory sees a fresh request.
                if (!gap) begin
                    mem_req  = rst;
                    mem_addr = fill_addr;
                    if (mem_ack) begin
                        cache_replace = 1'b1;
                        cache_addr    = fill_addr;
                        cache_din     = mem_rdata;
                        cache_u_b_h_w = WORD_SEL;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt        <= '0;
            req_addr   <= '0;
            req_wdata  <= '0;
            req_we     <= 1'b0;
            req_size   <= '0;
            victim_tag <= '0;
            gap        <= 1'b0;
        end else begin
            gap <= 1'b0;
            if (state == IDLE && cpu_req) begin
                req_addr  <= cpu_addr;
                req_wdata <= cpu_wdata;
                req_we    <= cpu_we;
                req_size  <= cpu_u_b_h_w;
            end
            if (state == COMPARE && !cache_hit && cache_valid && cache_dirty)
                victim_tag <= cache_tag;
            if ((state == WB || state == FILL) && xfer_done) begin
                cnt <= last_word ? '0 : cnt + CNT_W'(1);
                if (state == WB && last_word) gap <= 1'b1;
            end
        end
    end

`ifdef CACHE_CTRL_PERF_EN
    // The hit that completes a fill is not a real hit.
    logic retry;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                                      retry <= 1'b0;
        else if (state == FILL && state_nx == COMPARE) retry <= 1'b1;
        else if (state == COMPARE)                     retry <= 1'b0;
    end

    cache_perf_cnt u_perf (
        .clk      (clk),
        .rst      (rst),
        .hit_evt  (state == COMPARE && cache_hit && !retry),
        .miss_evt (state == COMPARE && !cache_hit),
        .wb_evt   (state == COMPARE && !cache_hit && cache_valid && cache_dirty),
        .hit_cnt  (hit_cnt),
        .miss_cnt (miss_cnt),
        .wb_cnt   (wb_cnt)
    );
`endif

endmodule
